// File: rtl/match_run_logger.sv
`default_nettype none
// ============================================================================
// match_run_logger - measures each high episode of match_in, counts episodes
// and queues their run lengths in a show-ahead FIFO drained via valid/ready.
// Revision: 1.0
// ============================================================================
module match_run_logger #(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   match_in,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [LEN_W-1:0]       rd_len,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       episode_cnt,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(DEPTH);

  logic [0:0]        state_q, state_d;
  logic [LEN_W-1:0]  run_len_q, run_len_d;
  logic [CNT_W-1:0]  episode_q, episode_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [LEN_W-1:0]  mem_q [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_write;

  assign w_full  = (count_q == FULL_CNT);
  assign w_pop   = (count_q != '0) && rd_ready;
  assign w_push  = (state_q == ST_RUN) && !match_in;
  // A full FIFO still accepts the entry when the head leaves at the same edge.
  assign w_write = w_push && (!w_full || w_pop);

  always_comb begin
    state_d    = state_q;
    run_len_d  = run_len_q;
    episode_d  = episode_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (match_in) begin
          state_d   = ST_RUN;
          run_len_d = {{(LEN_W-1){1'b0}}, 1'b1};
          episode_d = episode_q + 1'b1;
        end
      end
      default: begin
        if (match_in) begin
          if (run_len_q != LEN_MAX) begin
            run_len_d = run_len_q + 1'b1;
          end
        end else begin
          state_d   = ST_IDLE;
          run_len_d = '0;
        end
      end
    endcase

    if (w_write) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (w_write && !w_pop) begin
      count_d = count_q + 1'b1;
    end else if (!w_write && w_pop) begin
      count_d = count_q - 1'b1;
    end
    if (w_push && !w_write) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      run_len_q  <= '0;
      episode_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_len_q  <= run_len_d;
      episode_q  <= episode_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_write) begin
      mem_q[wr_ptr_q] <= run_len_q;
    end
  end

  assign rd_valid    = (count_q != '0);
  assign rd_len      = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count  = count_q;
  assign episode_cnt = episode_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire
